// File: rtl/servo_door_ctrl.sv
// Door sequencer feeding the servo PWM driver: settle timing, obstacle re-open, open counter.
// Optional hold-open auto-close is compiled in with `define DOOR_AUTOCLOSE_EN.
module servo_door_ctrl #(
   parameter int CLK_PER_MS = 1000,
   parameter int SETTLE_MS  = 500,
   parameter int HOLD_MS    = 5000
) (
   input  logic        clk_1MHz,
   input  logic        rst,
   input  logic        open_req,
   input  logic        close_req,
   input  logic        obstacle,
   output logic        servo_state,
   output logic [1:0]  door_state,
   output logic        busy,
   output logic [15:0] open_count
);

   localparam int MAX_MS = (HOLD_MS > SETTLE_MS) ? HOLD_MS : SETTLE_MS;
   localparam int PRE_W  = $clog2(CLK_PER_MS + 1);
   localparam int MS_W   = $clog2(MAX_MS + 1);
   localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CLK_PER_MS - 1);
   localparam logic [MS_W-1:0]  SETTLE_LAST = MS_W'(SETTLE_MS - 1);

   typedef enum logic [1:0] {
      CLOSED  = 2'b00,
      OPENING = 2'b01,
      OPEN    = 2'b10,
      CLOSING = 2'b11
   } state_t;

   state_t            state_reg, state_next;
   logic [PRE_W-1:0]  presc_reg;
   logic [MS_W-1:0]   ms_reg;
   logic              pending_reg, pending_next;
   logic              entry_close_reg, entry_close_next;
   logic              servo_reg, busy_reg;
   logic [15:0]       count_reg;
   logic              timer_clear, timer_run, count_inc;
   logic              ms_tick, settle_done;

   assign ms_tick     = (presc_reg == PRE_LAST);
   assign settle_done = ms_tick && (ms_reg == SETTLE_LAST);

`ifdef DOOR_AUTOCLOSE_EN
   localparam logic [MS_W-1:0] HOLD_LAST = MS_W'(HOLD_MS - 1);
   logic hold_done;
   assign hold_done = ms_tick && (ms_reg == HOLD_LAST);
`endif

   always_comb begin
      state_next       = state_reg;
      pending_next     = pending_reg;
      entry_close_next = 1'b0;
      timer_clear      = 1'b0;
      count_inc        = 1'b0;
      timer_run        = 1'b0;
      unique case (state_reg)
         CLOSED: begin
            if (open_req) begin
               state_next   = OPENING;
               count_inc    = 1'b1;
               timer_clear  = 1'b1;
               pending_next = 1'b0;
            end
         end
         OPENING: begin
            timer_run = 1'b1;
            if (close_req) pending_next = 1'b1;
            if (settle_done) begin
               state_next       = OPEN;
               timer_clear      = 1'b1;
               // A close seen at any point during travel is acted on in OPEN's first cycle.
               entry_close_next = pending_reg | close_req;
               pending_next     = 1'b0;
            end
         end
         OPEN: begin
`ifdef DOOR_AUTOCLOSE_EN
            timer_run = 1'b1;
`endif
            if (entry_close_reg && !obstacle) begin
               state_next  = CLOSING;
               timer_clear = 1'b1;
            end else if (obstacle || open_req) begin
               timer_clear = 1'b1;
            end else if (close_req) begin
               state_next  = CLOSING;
               timer_clear = 1'b1;
`ifdef DOOR_AUTOCLOSE_EN
            end else if (hold_done) begin
               state_next  = CLOSING;
               timer_clear = 1'b1;
`endif
            end
         end
         CLOSING: begin
            timer_run = 1'b1;
            if (obstacle || open_req) begin
               state_next  = OPENING;
               count_inc   = 1'b1;
               timer_clear = 1'b1;
            end else if (settle_done) begin
               state_next  = CLOSED;
               timer_clear = 1'b1;
            end
         end
         default: state_next = CLOSED;
      endcase
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         state_reg       <= CLOSED;
         pending_reg     <= 1'b0;
         entry_close_reg <= 1'b0;
         servo_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         count_reg       <= 16'd0;
         presc_reg       <= '0;
         ms_reg          <= '0;
      end else begin
         state_reg       <= state_next;
         pending_reg     <= pending_next;
         entry_close_reg <= entry_close_next;
         servo_reg       <= (state_next == OPENING) || (state_next == OPEN);
         busy_reg        <= (state_next == OPENING) || (state_next == CLOSING);
         if (count_inc && (count_reg != 16'hFFFF)) count_reg <= count_reg + 16'd1;
         if (timer_clear || !timer_run) begin
            presc_reg <= '0;
            ms_reg    <= '0;
         end else if (ms_tick) begin
            presc_reg <= '0;
            ms_reg    <= ms_reg + 1'b1;
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end
      end
   end

   assign servo_state = servo_reg;
   assign door_state  = state_reg;
   assign busy        = busy_reg;
   assign open_count  = count_reg;

endmodule

// File: tb/tb_servo_door_ctrl.sv
// Randomised + directed bench for servo_door_ctrl against a cycle-count door model.
// Follows DOOR_AUTOCLOSE_EN the same way the design does.
module tb_servo_door_ctrl;

   localparam int CPM    = 10;
   localparam int SETTLE = 3;
   localparam int HOLD   = 5;
   localparam int SETTLE_CYC = SETTLE * CPM;
   localparam int HOLD_CYC   = HOLD * CPM;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        open_req = 1'b0;
   logic        close_req = 1'b0;
   logic        obstacle = 1'b0;
   logic        servo_state;
   logic [1:0]  door_state;
   logic        busy;
   logic [15:0] open_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // model: state 0 closed, 1 opening, 2 open, 3 closing
   int m_state = 0;
   int m_elapsed = 0;
   int m_count = 0;
   bit m_pend = 1'b0;
   bit m_entry = 1'b0;

`ifdef DOOR_AUTOCLOSE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   servo_door_ctrl #(.CLK_PER_MS(CPM), .SETTLE_MS(SETTLE), .HOLD_MS(HOLD)) dut (
      .clk_1MHz   (clk),
      .rst        (rst),
      .open_req   (open_req),
      .close_req  (close_req),
      .obstacle   (obstacle),
      .servo_state(servo_state),
      .door_state (door_state),
      .busy       (busy),
      .open_count (open_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One edge of the door rules, in terms of cycles spent since entry/reload.
   task automatic model_step(input bit o, input bit c, input bit ob, input bit r);
      int  nxt;
      int  done;
      bit  restart;
      bit  new_entry;
      if (r) begin
         m_state = 0; m_elapsed = 0; m_count = 0; m_pend = 0; m_entry = 0;
         return;
      end
      nxt = m_state; restart = 0; new_entry = 0;
      done = m_elapsed + 1;
      case (m_state)
         0: if (o) begin nxt = 1; restart = 1; if (m_count < 65535) m_count++; end
         1: begin
            if (c) m_pend = 1;
            if (done == SETTLE_CYC) begin
               nxt = 2; restart = 1; new_entry = m_pend; m_pend = 0;
            end
         end
         2: begin
            if (m_entry && !ob) begin nxt = 3; restart = 1; end
            else if (ob || o) restart = 1;
            else if (c) begin nxt = 3; restart = 1; end
            else if (AUTO && done == HOLD_CYC) begin nxt = 3; restart = 1; end
         end
         default: begin
            if (ob || o) begin nxt = 1; restart = 1; if (m_count < 65535) m_count++; end
            else if (done == SETTLE_CYC) begin nxt = 0; restart = 1; end
         end
      endcase
      m_entry = new_entry;
      m_state = nxt;
      m_elapsed = restart ? 0 : done;
   endtask

   task automatic cycle(input bit o, input bit c, input bit ob, input bit r);
      @(negedge clk);
      open_req = o; close_req = c; obstacle = ob; rst = r;
      @(posedge clk);
      model_step(o, c, ob, r);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("door_state", {14'd0, door_state}, 16'(m_state));
         chk("servo_state", {15'd0, servo_state}, {15'd0, (m_state == 1 || m_state == 2)});
         chk("busy", {15'd0, busy}, {15'd0, (m_state == 1 || m_state == 3)});
         chk("open_count", open_count, 16'(m_count));
      end
   end

   task automatic to_closing_from_open();
      if (AUTO) begin
         idle(HOLD_CYC - 1);
         chk("hold_not_yet", {14'd0, door_state}, 16'd2);
         cycle(0, 0, 0, 0);
      end else begin
         idle(1000);
         chk("open_persists", {14'd0, door_state}, 16'd2);
         cycle(0, 1, 0, 0);
      end
      chk("enter_closing", {14'd0, door_state}, 16'd3);
   endtask

   initial begin
      int ob_run;
      bit o, c, ob, r;
      cycle(0, 0, 0, 1);
      chk_en = 1'b1;
      cycle(0, 0, 0, 1);
      chk("rst_door", {14'd0, door_state}, 16'd0);
      chk("rst_count", open_count, 16'd0);

      // basic open / settle / close cycle
      cycle(1, 0, 0, 0);
      chk("open_door", {14'd0, door_state}, 16'd1);
      chk("open_servo", {15'd0, servo_state}, 16'd1);
      chk("open_busy", {15'd0, busy}, 16'd1);
      chk("open_count1", open_count, 16'd1);
      idle(SETTLE_CYC - 1);
      chk("settle_not_yet", {14'd0, door_state}, 16'd1);
      cycle(0, 0, 0, 0);
      chk("settle_open", {14'd0, door_state}, 16'd2);
      to_closing_from_open();
      chk("closing_servo", {15'd0, servo_state}, 16'd0);
      idle(SETTLE_CYC - 1);
      cycle(0, 0, 0, 0);
      chk("closed", {14'd0, door_state}, 16'd0);
      chk("closed_busy", {15'd0, busy}, 16'd0);
      $display("phase basic done t=%0t", $time);

      // obstacle re-open at cycle 15 of CLOSING
      cycle(1, 0, 0, 0);
      idle(SETTLE_CYC);
      to_closing_from_open();
      idle(14);
      cycle(0, 0, 1, 0);
      chk("reopen_door", {14'd0, door_state}, 16'd1);
      chk("reopen_servo", {15'd0, servo_state}, 16'd1);
      chk("reopen_count", open_count, 16'd3);
      idle(SETTLE_CYC - 1);
      chk("reopen_settle", {14'd0, door_state}, 16'd1);
      cycle(0, 0, 0, 0);
      chk("reopen_open", {14'd0, door_state}, 16'd2);
      $display("phase reopen done t=%0t", $time);

      // pending close from OPENING
      cycle(0, 1, 0, 0);
      idle(SETTLE_CYC);
      chk("back_closed", {14'd0, door_state}, 16'd0);
      cycle(1, 0, 0, 0);
      idle(4);
      cycle(0, 1, 0, 0);
      idle(SETTLE_CYC - 6);
      chk("pend_opening", {14'd0, door_state}, 16'd1);
      cycle(0, 0, 0, 0);
      chk("pend_open", {14'd0, door_state}, 16'd2);
      cycle(0, 0, 0, 0);
      chk("pend_closing", {14'd0, door_state}, 16'd3);
      idle(SETTLE_CYC);
      cycle(1, 0, 0, 0);
      chk("count5", open_count, 16'd5);
      idle(4);
      cycle(0, 1, 0, 0);
      idle(SETTLE_CYC - 5);
      chk("pend2_open", {14'd0, door_state}, 16'd2);
      cycle(0, 0, 1, 0);
      chk("pend2_obstacle", {14'd0, door_state}, 16'd2);
      cycle(0, 0, 0, 0);
      chk("pend2_discarded", {14'd0, door_state}, 16'd2);
      $display("phase pending done t=%0t", $time);

      // long obstacle in OPEN
      for (int i = 0; i < 200; i++) cycle(0, 0, 1, 0);
      chk("obst_open", {14'd0, door_state}, 16'd2);
      to_closing_from_open();
      idle(SETTLE_CYC);
      $display("phase obstacle done t=%0t", $time);

      // reset mid-OPENING, then simultaneous open+close in CLOSED
      cycle(1, 0, 0, 0);
      idle(9);
      cycle(0, 0, 0, 1);
      chk("midrst_door", {14'd0, door_state}, 16'd0);
      chk("midrst_servo", {15'd0, servo_state}, 16'd0);
      chk("midrst_count", open_count, 16'd0);
      cycle(1, 1, 0, 0);
      chk("both_req", {14'd0, door_state}, 16'd1);
      chk("both_count", open_count, 16'd1);
      $display("phase reset done t=%0t", $time);

      // randomised traffic
      ob_run = 0;
      for (int i = 0; i < 4000; i++) begin
         if (ob_run > 0) ob_run--;
         else if ($urandom_range(0, 40) == 0) ob_run = $urandom_range(1, 60);
         o  = ($urandom_range(0, 60) == 0);
         c  = ($urandom_range(0, 25) == 0);
         ob = (ob_run > 0);
         r  = ($urandom_range(0, 700) == 0);
         cycle(o, c, ob, r);
      end
      $display("phase random done t=%0t", $time);

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
